// File: rtl/instr_queue_if.sv
// Fetch/decode handshake bundle for instr_queue.
// The queue connects to the slave modport; the environment drives the master side.
interface instr_queue_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          fetch_valid_i;
  logic [31:0]   fetch_instr_i;
  logic [31:0]   fetch_pc_i;
  logic          fetch_stall_o;
  logic          flush_i;
  logic          valid_o;
  logic [31:0]   instr_o;
  logic [31:0]   pc_o;
  logic          ready_i;
  logic [CW-1:0] count_o;

  modport master (
    output fetch_valid_i, fetch_instr_i, fetch_pc_i, flush_i, ready_i,
    input  fetch_stall_o, valid_o, instr_o, pc_o, count_o
  );

  modport slave (
    input  fetch_valid_i, fetch_instr_i, fetch_pc_i, flush_i, ready_i,
    output fetch_stall_o, valid_o, instr_o, pc_o, count_o
  );
endinterface

// File: rtl/instr_queue.sv
// Show-ahead fetch->decode FIFO of {pc, instr} pairs with full-stall and flush.
// Outputs depend only on registered state; no bypass from fetch to decode.
module instr_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  instr_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            full, empty, push, pop;
  entry_t          head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = q.fetch_valid_i && !full && !q.flush_i;
  assign pop   = !empty && q.ready_i && !q.flush_i;

  // Flush only rewinds pointers; stale storage is unreachable once count is 0.
  always_ff @(posedge clk_i) begin
    if (rst_i || q.flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wptr] <= '{pc: q.fetch_pc_i, instr: q.fetch_instr_i};
  end

  assign head            = mem[rptr];
  assign q.valid_o       = !empty;
  assign q.instr_o       = empty ? 32'h0 : head.instr;
  assign q.pc_o          = empty ? 32'h0 : head.pc;
  assign q.fetch_stall_o = full;
  assign q.count_o       = count;
endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed fetch/decode sequences, with a
// separate monitor checking every handshake against the expected stream.
module tb_instr_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_queue_if #(.DEPTH(DEPTH)) q ();
  instr_queue #(.DEPTH(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .q(q.slave));

  logic [63:0] sb [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          mcount = 0;
  bit          model_ok = 1'b0;

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted head must match the oldest expected pair.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (model_ok && !rst && !q.flush_i && q.valid_o === 1'b1 && q.ready_i) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL mon_unexpected: got pc 0x%08h expected no output", q.pc_o);
        end else begin
          e = sb.pop_front();
          chk("mon_pc", q.pc_o, e[63:32]);
          chk("mon_instr", q.instr_o, e[31:0]);
        end
      end
    end
  end

  // One cycle of stimulus; checks the registered-state outputs against the model,
  // then advances the model by what this cycle should do.
  task automatic step(input logic fv, input logic [31:0] pc, input logic rdy,
                      input logic fl, input logic r);
    bit acc, pp;
    rst = r;
    q.fetch_valid_i = fv;
    q.fetch_pc_i    = pc;
    q.fetch_instr_i = mk(pc);
    q.ready_i       = rdy;
    q.flush_i       = fl;
    @(negedge clk);
    if (model_ok) begin
      chk("count", 32'(q.count_o), 32'(mcount));
      chk("valid", 32'(q.valid_o), 32'(mcount != 0));
      chk("stall", 32'(q.fetch_stall_o), 32'(mcount == DEPTH));
      if (mcount == 0) begin
        chk("idle_instr", q.instr_o, 32'h0);
        chk("idle_pc", q.pc_o, 32'h0);
      end
    end
    if (r) begin
      mcount = 0; sb.delete(); model_ok = 1'b1;
    end else if (fl) begin
      mcount = 0; sb.delete();
    end else begin
      acc = fv && (mcount != DEPTH);
      pp  = rdy && (mcount != 0);
      if (acc) sb.push_back({pc, mk(pc)});
      mcount = mcount + int'(acc) - int'(pp);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    q.fetch_valid_i = 1'b0; q.fetch_pc_i = '0; q.fetch_instr_i = '0;
    q.ready_i = 1'b0; q.flush_i = 1'b0;

    // Reset
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 32'(q.valid_o), 32'd0);
    chk("rst_count", 32'(q.count_o), 32'd0);
    chk("rst_stall", 32'(q.fetch_stall_o), 32'd0);
    chk("rst_pc", q.pc_o, 32'h0);

    // Stream with ready held high: one-cycle latency, count never above 1
    step(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    chk("stream_lat_pc", q.pc_o, 32'h8000_0000);
    step(1'b1, 32'h8000_0004, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0008, 1'b1, 1'b0, 1'b0);
    chk("stream_count", 32'(q.count_o), 32'd1);
    drain(2);

    // Fill to DEPTH, fifth pair refused until space appears
    for (int i = 0; i < 4; i++) step(1'b1, 32'h8000_0000 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    chk("fill_count", 32'(q.count_o), 32'd4);
    chk("fill_stall", 32'(q.fetch_stall_o), 32'd1);
    step(1'b1, 32'h8000_0010, 1'b0, 1'b0, 1'b0);
    chk("fill_hold_count", 32'(q.count_o), 32'd4);
    step(1'b1, 32'h8000_0010, 1'b1, 1'b0, 1'b0);
    chk("full_pop_count", 32'(q.count_o), 32'd3);
    chk("full_pop_stall", 32'(q.fetch_stall_o), 32'd0);
    step(1'b1, 32'h8000_0010, 1'b1, 1'b0, 1'b0);
    drain(5);

    // Simultaneous push and pop at count 2
    step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b0);
    chk("pp_head0", q.pc_o, 32'h8000_0000);
    step(1'b1, 32'h8000_0008, 1'b1, 1'b0, 1'b0);
    chk("pp_count", 32'(q.count_o), 32'd2);
    chk("pp_head1", q.pc_o, 32'h8000_0004);
    drain(3);

    // Wrap: interleaved push/pop across several pointer laps
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h8000_1000 + 32'(4*i), (i % 2) == 0, 1'b0, 1'b0);
    drain(8);
    chk("wrap_count", 32'(q.count_o), 32'd0);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Flush with 3 entries and a pair being presented
    for (int i = 0; i < 3; i++) step(1'b1, 32'h8000_0020 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0100, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", 32'(q.valid_o), 32'd0);
    chk("flush_count", 32'(q.count_o), 32'd0);
    chk("flush_instr", q.instr_o, 32'h0);
    chk("flush_pc", q.pc_o, 32'h0);
    step(1'b1, 32'h8000_0200, 1'b0, 1'b0, 1'b0);
    chk("post_flush_pc", q.pc_o, 32'h8000_0200);
    drain(2);

    // Flush while full releases stall next cycle
    for (int i = 0; i < 4; i++) step(1'b1, 32'h8000_0400 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0410, 1'b0, 1'b1, 1'b0);
    chk("flush_full_stall", 32'(q.fetch_stall_o), 32'd0);

    // Reset with count 3 and a push pending
    for (int i = 0; i < 3; i++) step(1'b1, 32'h8000_0300 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0310, 1'b1, 1'b0, 1'b1);
    chk("rst2_valid", 32'(q.valid_o), 32'd0);
    chk("rst2_count", 32'(q.count_o), 32'd0);
    chk("rst2_instr", q.instr_o, 32'h0);
    chk("rst2_pc", q.pc_o, 32'h0);
    chk("rst2_stall", 32'(q.fetch_stall_o), 32'd0);
    drain(2);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
